// File: rtl/lcd_key_pkg.sv
// Shared types and constants for the LCD key controller.
// HD44780 command bytes and the PS/2 scan codes that get special handling.
package lcd_key_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInit,
        StIdle,
        StSetup,
        StPulse,
        StWait
    } state_e;

    localparam logic [7:0] CmdFuncSet = 8'h38;
    localparam logic [7:0] CmdDispOn  = 8'h0C;
    localparam logic [7:0] CmdClear   = 8'h01;
    localparam logic [7:0] CmdEntry   = 8'h06;
    localparam logic [7:0] CmdLine1   = 8'h80;
    localparam logic [7:0] CmdLine2   = 8'hC0;

    localparam logic [7:0] KeyEnter   = 8'h5A;
    localparam logic [7:0] KeyBksp    = 8'h66;
    localparam logic [7:0] KeyEsc     = 8'h76;
    localparam logic [7:0] KeyShiftL  = 8'h12;
    localparam logic [7:0] KeyShiftR  = 8'h59;
    localparam logic [7:0] KeyCaps    = 8'h58;

    // Set-DDRAM-address command for a 0..31 cursor; line 2 starts at DDRAM 0x40.
    function automatic logic [7:0] set_addr(input logic [4:0] c);
        return (c[4] ? CmdLine2 : CmdLine1) | {4'h0, c[3:0]};
    endfunction

endpackage

// File: rtl/lcd_key_ctrl_if.sv
// Key input and LCD bus bundle for lcd_key_ctrl.
// The controller uses the slave modport; the key source / LCD side uses master.
interface lcd_key_ctrl_if;

    logic       key_valid;
    logic [7:0] key_code;
    logic       upper;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic [4:0] cursor;

    modport master (
        output key_valid, key_code, upper,
        input  lcd_rs, lcd_rw, lcd_e, lcd_data, busy, cursor
    );

    modport slave (
        input  key_valid, key_code, upper,
        output lcd_rs, lcd_rw, lcd_e, lcd_data, busy, cursor
    );

endinterface

// File: rtl/ps2_to_ascii.sv
// Combinational PS/2 set-2 make code to ASCII translation.
// Letters honour upper; digits, space and punctuation are case independent.
module ps2_to_ascii (
    input  logic [7:0] key_code,
    input  logic       upper,
    output logic [7:0] ascii,
    output logic       valid
);

    logic [7:0] lower;
    logic       letter;

    always_comb begin
        lower = 8'h00;
        valid = 1'b1;
        case (key_code)
            8'h1C: lower = "a";
            8'h32: lower = "b";
            8'h21: lower = "c";
            8'h23: lower = "d";
            8'h24: lower = "e";
            8'h2B: lower = "f";
            8'h34: lower = "g";
            8'h33: lower = "h";
            8'h43: lower = "i";
            8'h3B: lower = "j";
            8'h42: lower = "k";
            8'h4B: lower = "l";
            8'h3A: lower = "m";
            8'h31: lower = "n";
            8'h44: lower = "o";
            8'h4D: lower = "p";
            8'h15: lower = "q";
            8'h2D: lower = "r";
            8'h1B: lower = "s";
            8'h2C: lower = "t";
            8'h3C: lower = "u";
            8'h2A: lower = "v";
            8'h1D: lower = "w";
            8'h22: lower = "x";
            8'h35: lower = "y";
            8'h1A: lower = "z";
            8'h45: lower = "0";
            8'h16: lower = "1";
            8'h1E: lower = "2";
            8'h26: lower = "3";
            8'h25: lower = "4";
            8'h2E: lower = "5";
            8'h36: lower = "6";
            8'h3D: lower = "7";
            8'h3E: lower = "8";
            8'h46: lower = "9";
            8'h29: lower = " ";
            8'h41: lower = ",";
            8'h49: lower = ".";
            8'h4A: lower = "/";
            8'h4E: lower = "-";
            8'h55: lower = "=";
            default: valid = 1'b0;
        endcase
        letter = (lower >= "a") && (lower <= "z");
        ascii  = (upper && letter) ? (lower - 8'h20) : lower;
    end

endmodule

// File: rtl/lcd_key_ctrl.sv
// HD44780 controller that types PS/2 make codes onto a 16x2 LCD.
// Define LCD_CLEAR_KEY_EN to make Esc (0x76) clear the display and home the cursor.
module lcd_key_ctrl
    import lcd_key_pkg::*;
#(
    parameter int unsigned E_HIGH_CYC   = 12,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWRUP_CYC    = 750000
) (
    input logic           clk,
    input logic           rst,
    lcd_key_ctrl_if.slave bus
);

    localparam int unsigned MaxCyc = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    typedef logic [CntW-1:0] cnt_t;

    state_e          state_q, state_d;
    cnt_t            cnt_q, cnt_d;
    logic [4:0]      cursor_q, cursor_d;
    // Pending bus writes as {rs, data}; idx walks entries 0..last.
    logic [3:0][8:0] seq_q, seq_d;
    logic [1:0]      idx_q, idx_d, last_q, last_d;

    logic [7:0] ascii;
    logic       ascii_ok;
    logic       is_mod;
    logic [8:0] cur_wr;
    logic [4:0] cur_inc, cur_dec;
    cnt_t       wait_end;

    ps2_to_ascii u_xlate (
        .key_code (bus.key_code),
        .upper    (bus.upper),
        .ascii    (ascii),
        .valid    (ascii_ok)
    );

    assign is_mod   = (bus.key_code == KeyShiftL) || (bus.key_code == KeyShiftR) ||
                      (bus.key_code == KeyCaps);
    assign cur_wr   = seq_q[idx_q];
    assign cur_inc  = cursor_q + 5'd1;
    assign cur_dec  = cursor_q - 5'd1;
    assign wait_end = (cur_wr == {1'b0, CmdClear}) ? cnt_t'(CLR_WAIT_CYC - 1)
                                                   : cnt_t'(CMD_WAIT_CYC - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        last_d   = last_q;
        unique case (state_q)
            StPwrup: begin
                if (cnt_q == cnt_t'(PWRUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StInit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StInit: begin
                seq_d    = {{1'b0, CmdEntry}, {1'b0, CmdClear},
                            {1'b0, CmdDispOn}, {1'b0, CmdFuncSet}};
                idx_d    = 2'd0;
                last_d   = 2'd3;
                cursor_d = 5'd0;
                state_d  = StSetup;
            end
            StIdle: begin
                if (bus.key_valid) begin
                    idx_d = 2'd0;
                    if (bus.key_code == KeyEnter) begin
                        seq_d[0] = {1'b0, cursor_q[4] ? CmdLine1 : CmdLine2};
                        cursor_d = cursor_q[4] ? 5'd0 : 5'd16;
                        last_d   = 2'd0;
                        state_d  = StSetup;
                    end else if (bus.key_code == KeyBksp) begin
                        if (cursor_q != 5'd0) begin
                            seq_d[0] = {1'b0, set_addr(cur_dec)};
                            seq_d[1] = {1'b1, 8'h20};
                            seq_d[2] = {1'b0, set_addr(cur_dec)};
                            cursor_d = cur_dec;
                            last_d   = 2'd2;
                            state_d  = StSetup;
                        end
                    end
`ifdef LCD_CLEAR_KEY_EN
                    else if (bus.key_code == KeyEsc) begin
                        seq_d[0] = {1'b0, CmdClear};
                        cursor_d = 5'd0;
                        last_d   = 2'd0;
                        state_d  = StSetup;
                    end
`endif
                    else if (ascii_ok && !is_mod) begin
                        seq_d[0] = {1'b1, ascii};
                        // LCD auto-increment does not follow line changes; re-address on 16 and 0.
                        seq_d[1] = {1'b0, cur_inc[4] ? CmdLine2 : CmdLine1};
                        last_d   = (cur_inc[3:0] == 4'd0) ? 2'd1 : 2'd0;
                        cursor_d = cur_inc;
                        state_d  = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StPulse;
            end
            StPulse: begin
                if (cnt_q == cnt_t'(E_HIGH_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == wait_end) begin
                    cnt_d = '0;
                    if (idx_q == last_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StSetup;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StPwrup;
            cnt_q    <= '0;
            cursor_q <= 5'd0;
            seq_q    <= '0;
            idx_q    <= 2'd0;
            last_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cursor_q <= cursor_d;
            seq_q    <= seq_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

    assign bus.lcd_rs   = cur_wr[8];
    assign bus.lcd_data = cur_wr[7:0];
    assign bus.lcd_e    = (state_q == StPulse);
    assign bus.lcd_rw   = 1'b0;
    assign bus.busy     = (state_q != StIdle);
    assign bus.cursor   = cursor_q;

endmodule

// File: tb/tb_lcd_key_ctrl.sv
// Directed self-checking bench for lcd_key_ctrl with shortened timing parameters.
// Honours LCD_CLEAR_KEY_EN the same way as the design.
module tb_lcd_key_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_cur;
    int   n;

    logic [7:0] fill_code [16];
    logic [7:0] fill_lo   [16];
    logic [7:0] fill_hi   [16];
    logic [7:0] ign_code  [5];

    lcd_key_ctrl_if bus ();

    lcd_key_ctrl #(
        .E_HIGH_CYC   (2),
        .CMD_WAIT_CYC (4),
        .CLR_WAIT_CYC (8),
        .PWRUP_CYC    (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] code, input logic up);
        bus.key_code  = code;
        bus.upper     = up;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
    endtask

    // gap = cycles from call until lcd_e is seen high.
    task automatic expect_write(input string tag, input logic rs, input logic [7:0] d,
                                input int gap);
        int w;
        int hi;
        w = 0;
        while (bus.lcd_e !== 1'b1 && w < 400) begin
            step();
            w++;
        end
        check({tag, " gap"}, w, gap);
        check({tag, " rs"}, bus.lcd_rs, rs);
        check({tag, " data"}, bus.lcd_data, d);
        hi = 0;
        while (bus.lcd_e === 1'b1 && hi < 400) begin
            step();
            hi++;
        end
        check({tag, " e_high"}, hi, 2);
        check({tag, " data hold"}, bus.lcd_data, d);
    endtask

    task automatic wait_idle(input string tag, input int cyc);
        int w;
        w = 0;
        while (bus.busy !== 1'b0 && w < 400) begin
            step();
            w++;
        end
        check({tag, " idle"}, w, cyc);
    endtask

    task automatic quiet(input string tag, input int cyc);
        int e_seen;
        int b_seen;
        e_seen = 0;
        b_seen = 0;
        for (int i = 0; i < cyc; i++) begin
            if (bus.lcd_e === 1'b1) e_seen++;
            if (bus.busy === 1'b1) b_seen++;
            step();
        end
        check({tag, " e quiet"}, e_seen, 0);
        check({tag, " busy quiet"}, b_seen, 0);
    endtask

    task automatic run_init(input string tag);
        expect_write({tag, " 0x38"}, 1'b0, 8'h38, 12);
        expect_write({tag, " 0x0C"}, 1'b0, 8'h0C, 5);
        expect_write({tag, " 0x01"}, 1'b0, 8'h01, 5);
        expect_write({tag, " 0x06"}, 1'b0, 8'h06, 9);
        wait_idle(tag, 4);
        check({tag, " cursor"}, bus.cursor, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fill_code = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                      8'h46, 8'h45, 8'h29, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        fill_lo   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                      8'h39, 8'h30, 8'h20, 8'h71, 8'h77, 8'h65, 8'h72, 8'h74};
        fill_hi   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                      8'h39, 8'h30, 8'h20, 8'h51, 8'h57, 8'h45, 8'h52, 8'h54};
        ign_code  = '{8'h12, 8'h59, 8'h58, 8'h00, 8'h05};
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.upper     = 1'b0;

        // Reset values
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("reset busy", bus.busy, 1);
        check("reset e", bus.lcd_e, 0);
        check("reset rs", bus.lcd_rs, 0);
        check("reset data", bus.lcd_data, 8'h00);
        check("reset cursor", bus.cursor, 0);
        check("reset rw", bus.lcd_rw, 0);
        repeat (3) step();
        rst = 1'b1;
        run_init("init");

        // Case selection
        check("idle busy", bus.busy, 0);
        press(8'h1C, 1'b1);
        check("busy rise", bus.busy, 1);
        expect_write("key A", 1'b1, 8'h41, 1);
        wait_idle("key A", 4);
        check("key A cursor", bus.cursor, 1);
        press(8'h1C, 1'b0);
        expect_write("key a", 1'b1, 8'h61, 1);
        wait_idle("key a", 4);
        check("key a cursor", bus.cursor, 2);

        // Enter toggles lines
        press(8'h5A, 1'b0);
        expect_write("enter l1", 1'b0, 8'hC0, 1);
        wait_idle("enter l1", 4);
        check("enter l1 cursor", bus.cursor, 16);
        press(8'h5A, 1'b0);
        expect_write("enter l2", 1'b0, 8'h80, 1);
        wait_idle("enter l2", 4);
        check("enter l2 cursor", bus.cursor, 0);

        // Fill line 1, then line 2 with wrap
        for (int i = 0; i < 16; i++) begin
            press(fill_code[i], 1'b0);
            expect_write("fill1", 1'b1, fill_lo[i], 1);
            if (i == 15) expect_write("fill1 cmd", 1'b0, 8'hC0, 5);
            wait_idle("fill1", 4);
        end
        check("fill1 cursor", bus.cursor, 16);
        for (int i = 0; i < 16; i++) begin
            press(fill_code[i], 1'b1);
            expect_write("fill2", 1'b1, fill_hi[i], 1);
            if (i == 15) expect_write("fill2 cmd", 1'b0, 8'h80, 5);
            wait_idle("fill2", 4);
        end
        check("fill2 cursor", bus.cursor, 0);

        // Backspace at cursor 5, then at cursor 0
        for (int i = 0; i < 5; i++) begin
            press(8'h32, 1'b0);
            expect_write("pre bs", 1'b1, 8'h62, 1);
            wait_idle("pre bs", 4);
        end
        check("pre bs cursor", bus.cursor, 5);
        press(8'h66, 1'b0);
        expect_write("bs addr1", 1'b0, 8'h84, 1);
        expect_write("bs space", 1'b1, 8'h20, 5);
        expect_write("bs addr2", 1'b0, 8'h84, 5);
        wait_idle("bs", 4);
        check("bs cursor", bus.cursor, 4);
        press(8'h5A, 1'b0);
        expect_write("bs enter1", 1'b0, 8'hC0, 1);
        wait_idle("bs enter1", 4);
        press(8'h5A, 1'b0);
        expect_write("bs enter2", 1'b0, 8'h80, 1);
        wait_idle("bs enter2", 4);
        press(8'h66, 1'b0);
        quiet("bs at 0", 20);
        check("bs at 0 cursor", bus.cursor, 0);

        // Modifiers and untranslatable codes
        press(8'h1C, 1'b0);
        expect_write("pre ign", 1'b1, 8'h61, 1);
        wait_idle("pre ign", 4);
        for (int i = 0; i < 5; i++) begin
            press(ign_code[i], 1'b1);
            quiet("ignored", 10);
        end
        check("ignored cursor", bus.cursor, 1);

        // Esc
        press(8'h76, 1'b0);
`ifdef LCD_CLEAR_KEY_EN
        expect_write("esc", 1'b0, 8'h01, 1);
        wait_idle("esc", 8);
        exp_cur = 0;
`else
        quiet("esc", 20);
        exp_cur = 1;
`endif
        check("esc cursor", bus.cursor, exp_cur);

        // key_valid during PULSE is dropped
        press(8'h32, 1'b0);
        n = 0;
        while (bus.lcd_e !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("drop e seen", bus.lcd_e, 1);
        check("drop data", bus.lcd_data, 8'h62);
        press(8'h1C, 1'b1);
        wait_idle("drop", 5);
        check("drop cursor", bus.cursor, exp_cur + 1);
        quiet("drop after", 20);

        // Async reset in the middle of WAIT
        press(8'h1C, 1'b1);
        n = 0;
        while (bus.lcd_e !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("mid data", bus.lcd_data, 8'h41);
        repeat (3) step();
        check("mid in wait", bus.lcd_e, 0);
        check("mid cursor", bus.cursor, exp_cur + 2);
        rst = 1'b0;
        #1;
        check("mid rst e", bus.lcd_e, 0);
        check("mid rst cursor", bus.cursor, 0);
        check("mid rst busy", bus.busy, 1);
        check("mid rst rs", bus.lcd_rs, 0);
        check("mid rst data", bus.lcd_data, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        run_init("reinit");
        press(8'h1C, 1'b1);
        expect_write("post key", 1'b1, 8'h41, 1);
        wait_idle("post key", 4);
        check("post cursor", bus.cursor, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_key_ctrl.md
LCD_KEY_CTRL -- requirements
Module: lcd_key_ctrl

Interface
REQ-001 SHALL have parameter E_HIGH_CYC, default 12, lcd_e high time in clk cycles.
REQ-002 SHALL have parameter CMD_WAIT_CYC, default 2000, post-write wait for normal commands and data.
REQ-003 SHALL have parameter CLR_WAIT_CYC, default 82000, post-write wait after clear (0x01).
REQ-004 SHALL have parameter PWRUP_CYC, default 750000, wait after reset before the first init command.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 key_valid  in  1  one-cycle pulse, key_code valid.
REQ-008 key_code  in  8  PS/2 make scan code.
REQ-009 upper  in  1  case select from the key-state FSM, sampled with key_valid.
REQ-010 lcd_rs  out  1  0 = command, 1 = data.
REQ-011 lcd_rw  out  1  tied 0.
REQ-012 lcd_e  out  1  HD44780 enable strobe.
REQ-013 lcd_data  out  8  LCD bus.
REQ-014 busy  out  1  high whenever not in IDLE.
REQ-015 cursor  out  5  current DDRAM position, 0-15 line 1, 16-31 line 2.

Function
REQ-016 Main FSM states SHALL be PWRUP, INIT, IDLE, SETUP, PULSE, WAIT.
REQ-017 One bus write SHALL be: SETUP 1 cycle (rs/data driven, e=0) -> PULSE E_HIGH_CYC cycles (e=1) -> WAIT CMD_WAIT_CYC cycles, or CLR_WAIT_CYC for 0x01 (e=0); rs/data held stable throughout.
REQ-018 PWRUP SHALL last PWRUP_CYC cycles, then INIT SHALL issue 0x38, 0x0C, 0x01, 0x06 in order, then enter IDLE with cursor=0.
REQ-019 key_valid SHALL be accepted only in IDLE; a pulse while busy=1 SHALL be dropped with no side effect.
REQ-020 Accepted printable code SHALL be translated to ASCII, upper/lower per upper for letters, written as data at cursor, and cursor SHALL increment.
REQ-021 After a data write leaving cursor=16, command 0xC0 SHALL follow; leaving cursor=0 (wrap from 31), 0x80 SHALL follow.
REQ-022 0x5A (enter) SHALL set cursor=16 and issue 0xC0 if cursor<16, else cursor=0 and issue 0x80.
REQ-023 0x66 (backspace) at cursor=0 SHALL be ignored; otherwise cursor decrements and the sequence set-address(new cursor), data 0x20, set-address(new cursor) SHALL be issued.
REQ-024 Set-address command SHALL be 0x80|c for c<16, 0xC0|(c-16) otherwise.
REQ-025 Modifiers 0x12, 0x59, 0x58 and untranslatable codes SHALL be ignored; FSM stays IDLE, busy stays 0.
REQ-026 busy SHALL rise the cycle after an accepted key_valid and fall on the cycle IDLE is re-entered.
REQ-027 Delay counter SHALL be wide enough for max(PWRUP_CYC, CLR_WAIT_CYC) with no overflow.

Reset
REQ-028 rst low SHALL immediately force PWRUP, counter 0, cursor 0, lcd_e 0, lcd_rs 0, lcd_data 0x00, busy 1, aborting any write in progress.
REQ-029 On rst release the full power-up and INIT sequence SHALL rerun.

Configuration
REQ-030 With LCD_CLEAR_KEY_EN defined, 0x76 (Esc) SHALL issue 0x01 with CLR_WAIT_CYC wait and set cursor=0; undefined, 0x76 SHALL be ignored like any untranslatable code.

Structure
REQ-031 Package lcd_key_pkg SHALL hold the state enum, LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0) and special scan codes (0x5A, 0x66, 0x76, 0x12, 0x59, 0x58).
REQ-032 Combinational sub-module ps2_to_ascii (key_code, upper -> ascii, valid) SHALL perform translation.

Verification (E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_CYC=10)
REQ-033 Release reset -> 10 idle cycles, then rs=0 writes 0x38, 0x0C, 0x01, 0x06 each with e high 2 cycles; busy falls, cursor=0.
REQ-034 key 0x1C, upper=1 -> rs=1 data 0x41; cursor=1; with upper=0 -> 0x61.
REQ-035 16 printable keys from cursor 0 -> 16th data write followed by command 0xC0, cursor=16; 16 more -> command 0x80, cursor=0.
REQ-036 cursor=5, key 0x66 -> writes 0x84, data 0x20, 0x84; cursor=4; at cursor=0, 0x66 -> no lcd_e activity.
REQ-037 key_valid pulse during PULSE -> dropped, cursor unchanged; rst low mid-WAIT -> lcd_e=0, cursor=0 same cycle, init reruns.
REQ-038 key 0x76 -> with LCD_CLEAR_KEY_EN: command 0x01, 8-cycle wait, cursor=0; without: no lcd_e activity.
